cpu_trace_buffer: RTL and testbench

//  Synthesizable commit-trace recorder for the sccomp_dataflow CPU. Replaces per-cycle bench dumps of pc/inst.

---
 rtl/cpu_trace_pkg.sv | 37 +++
 rtl/trace_ram.sv | 24 ++
 rtl/cpu_trace_buffer.sv | 167 ++++++++++++++++
 tb/tb_cpu_trace_buffer.sv | 331 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_trace_pkg.sv
// Shared encodings and entry layout for the commit-trace recorder.
// Entry width depends on the TRACE_WB_EN build macro.
package cpu_trace_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ARMED   = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_DONE    = 2'd3
  } trace_state_e;

  typedef enum logic {
    MODE_STOP = 1'b0,
    MODE_WRAP = 1'b1
  } trace_mode_e;

  localparam int PC_W      = 32;
  localparam int INST_W    = 32;
  localparam int WB_W      = 38;
  localparam int PC_LSB    = 0;
  localparam int INST_LSB  = PC_LSB + PC_W;
  localparam int STAMP_LSB = INST_LSB + INST_W;

  // Entry layout, LSB first: pc, inst, stamp, then {wb_en,wb_rd,wb_data} when enabled.
  function automatic int entry_width(input int cw);
`ifdef TRACE_WB_EN
    return PC_W + INST_W + cw + WB_W;
`else
    return PC_W + INST_W + cw;
`endif
  endfunction

  function automatic int wb_lsb(input int cw);
    return STAMP_LSB + cw;
  endfunction

endpackage

// File: rtl/trace_ram.sv
// DEPTH x W trace storage: one synchronous write port, one asynchronous read port.
// Storage is intentionally not reset; validity is tracked by the owner's count.
module trace_ram #(
  parameter  int DEPTH = 16,
  parameter  int W     = 96,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic          clk_in,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [W-1:0]  wdata_i,
  input  logic [AW-1:0] raddr_i,
  output logic [W-1:0]  rdata_o
);

  logic [W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk_in) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/cpu_trace_buffer.sv
// Commit-trace recorder: captures retired pc/inst/stamp into a circular buffer, drained oldest-first.
// Build macro TRACE_WB_EN adds the register write-back fields and the rd_wb port.
//
//   state      | meaning
//   -----------+-----------------------------------------------
//   ST_IDLE    | nothing recorded, waiting for arm
//   ST_ARMED   | buffer cleared, waiting for start or trigger pc
//   ST_CAPTURE | every commit is written
//   ST_DONE    | recording frozen, entries drain over rd_valid/rd_ready
module cpu_trace_buffer
  import cpu_trace_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int CW    = 32
) (
  input  logic                   clk_in,
  input  logic                   reset,
  input  logic                   commit_valid,
  input  logic [31:0]            commit_pc,
  input  logic [31:0]            commit_inst,
`ifdef TRACE_WB_EN
  input  logic                   wb_en,
  input  logic [4:0]             wb_rd,
  input  logic [31:0]            wb_data,
`endif
  input  logic                   arm,
  input  logic                   stop,
  input  logic                   mode,
  input  logic                   trig_en,
  input  logic [31:0]            trig_pc,
  output logic                   rd_valid,
  input  logic                   rd_ready,
  output logic [31:0]            rd_pc,
  output logic [31:0]            rd_inst,
  output logic [CW-1:0]          rd_stamp,
`ifdef TRACE_WB_EN
  output logic [WB_W-1:0]        rd_wb,
`endif
  output logic [$clog2(DEPTH):0] count,
  output logic                   overflow,
  output logic [1:0]             state
);

  localparam int AW   = $clog2(DEPTH);
  localparam int CNTW = AW + 1;
  localparam int EW   = entry_width(CW);
  localparam logic [CNTW-1:0] FULL = CNTW'(DEPTH);

  trace_state_e    state_q, state_d;
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CNTW-1:0] count_q, count_d;
  logic            overflow_q, overflow_d;
  logic [CW-1:0]   stamp_q;
  logic            we;
  logic            full;
  logic            pop;
  logic [EW-1:0]   wdata;
  logic [EW-1:0]   rdata;

  assign full     = (count_q == FULL);
  assign rd_valid = (state_q == ST_DONE) && (count_q != '0);
  assign pop      = rd_valid && rd_ready;

  always_comb begin
    state_d    = state_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q;
    we         = 1'b0;
    if (arm) begin
      // arm wins over stop and swallows a same-cycle commit
      state_d    = ST_ARMED;
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      count_d    = '0;
      overflow_d = 1'b0;
    end else begin
      unique case (state_q)
        ST_IDLE: ;
        ST_ARMED: begin
          if (stop) begin
            state_d = ST_DONE;
          end else if (!trig_en) begin
            state_d = ST_CAPTURE;
          end else if (commit_valid && (commit_pc == trig_pc)) begin
            we      = 1'b1;
            count_d = count_q + CNTW'(1);
            state_d = ST_CAPTURE;
          end
        end
        ST_CAPTURE: begin
          if (commit_valid && (!full || (mode == MODE_WRAP))) begin
            we = 1'b1;
            if (full) begin
              rd_ptr_d   = rd_ptr_q + AW'(1);
              overflow_d = 1'b1;
            end else begin
              count_d = count_q + CNTW'(1);
            end
          end
          if (stop || ((mode == MODE_STOP) && (count_d == FULL))) state_d = ST_DONE;
        end
        ST_DONE: begin
          if (pop) begin
            count_d  = count_q - CNTW'(1);
            rd_ptr_d = rd_ptr_q + AW'(1);
            if (count_q == CNTW'(1)) state_d = ST_IDLE;
          end else if (stop && (count_q == '0)) begin
            state_d = ST_IDLE;
          end
        end
      endcase
      if (we) wr_ptr_d = wr_ptr_q + AW'(1);
    end
  end

  always_ff @(posedge clk_in) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      stamp_q    <= '0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      stamp_q    <= stamp_q + CW'(1);
    end
  end

`ifdef TRACE_WB_EN
  assign wdata = {wb_en, wb_rd, wb_data, stamp_q, commit_inst, commit_pc};
`else
  assign wdata = {stamp_q, commit_inst, commit_pc};
`endif

  trace_ram #(
    .DEPTH (DEPTH),
    .W     (EW)
  ) u_ram (
    .clk_in  (clk_in),
    .we_i    (we && reset),
    .waddr_i (wr_ptr_q),
    .wdata_i (wdata),
    .raddr_i (rd_ptr_q),
    .rdata_o (rdata)
  );

  // Outputs read zero whenever nothing is valid, so unreset storage never leaks out.
  assign rd_pc    = rd_valid ? rdata[PC_LSB +: PC_W]     : '0;
  assign rd_inst  = rd_valid ? rdata[INST_LSB +: INST_W] : '0;
  assign rd_stamp = rd_valid ? rdata[STAMP_LSB +: CW]    : '0;
`ifdef TRACE_WB_EN
  assign rd_wb    = rd_valid ? rdata[wb_lsb(CW) +: WB_W] : '0;
`endif

  assign count    = count_q;
  assign overflow = overflow_q;
  assign state    = state_q;

endmodule

// File: tb/tb_cpu_trace_buffer.sv
// Bench for cpu_trace_buffer (DEPTH=4, CW=32): directed scenarios then random traffic,
// all checked against a queue-based reference model. Honours TRACE_WB_EN.
module tb_cpu_trace_buffer;

  localparam int DEPTH = 4;
  localparam int CW    = 32;

  logic        clk_in = 1'b0;
  logic        reset = 1'b0;
  logic        commit_valid = 1'b0;
  logic [31:0] commit_pc = '0;
  logic [31:0] commit_inst = '0;
  logic        wb_en = 1'b0;
  logic [4:0]  wb_rd = '0;
  logic [31:0] wb_data = '0;
  logic        arm = 1'b0;
  logic        stop = 1'b0;
  logic        mode = 1'b0;
  logic        trig_en = 1'b0;
  logic [31:0] trig_pc = '0;
  logic        rd_ready = 1'b0;
  logic        rd_valid;
  logic [31:0] rd_pc;
  logic [31:0] rd_inst;
  logic [CW-1:0] rd_stamp;
  logic [37:0] rd_wb;
  logic [2:0]  count;
  logic        overflow;
  logic [1:0]  state;

  always #5 clk_in = ~clk_in;

  cpu_trace_buffer #(.DEPTH(DEPTH), .CW(CW)) dut (
    .clk_in       (clk_in),
    .reset        (reset),
    .commit_valid (commit_valid),
    .commit_pc    (commit_pc),
    .commit_inst  (commit_inst),
`ifdef TRACE_WB_EN
    .wb_en        (wb_en),
    .wb_rd        (wb_rd),
    .wb_data      (wb_data),
`endif
    .arm          (arm),
    .stop         (stop),
    .mode         (mode),
    .trig_en      (trig_en),
    .trig_pc      (trig_pc),
    .rd_valid     (rd_valid),
    .rd_ready     (rd_ready),
    .rd_pc        (rd_pc),
    .rd_inst      (rd_inst),
    .rd_stamp     (rd_stamp),
`ifdef TRACE_WB_EN
    .rd_wb        (rd_wb),
`endif
    .count        (count),
    .overflow     (overflow),
    .state        (state)
  );

`ifndef TRACE_WB_EN
  assign rd_wb = '0;
`endif

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    logic [31:0] stamp;
    logic [37:0] wb;
  } ent_t;

  // Reference model: 0 idle, 1 armed, 2 capture, 3 done; the queue holds entries oldest-first.
  int          m_state;
  ent_t        q[$];
  logic        m_ovf;
  logic [31:0] m_stamp;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_step();
    ent_t e;
    if (!reset) begin
      m_state = 0;
      q.delete();
      m_ovf   = 1'b0;
      m_stamp = '0;
    end else begin
      e.pc    = commit_pc;
      e.inst  = commit_inst;
      e.stamp = m_stamp;
      e.wb    = {wb_en, wb_rd, wb_data};
      if (arm) begin
        q.delete();
        m_ovf   = 1'b0;
        m_state = 1;
      end else begin
        case (m_state)
          1: begin
            if (stop) m_state = 3;
            else if (!trig_en) m_state = 2;
            else if (commit_valid && commit_pc == trig_pc) begin
              q.push_back(e);
              m_state = 2;
            end
          end
          2: begin
            if (commit_valid) begin
              if (q.size() < DEPTH) q.push_back(e);
              else if (mode) begin
                void'(q.pop_front());
                q.push_back(e);
                m_ovf = 1'b1;
              end
            end
            if (stop || (!mode && q.size() == DEPTH)) m_state = 3;
          end
          3: begin
            if (q.size() != 0 && rd_ready) begin
              void'(q.pop_front());
              if (q.size() == 0) m_state = 0;
            end else if (q.size() == 0 && stop) begin
              m_state = 0;
            end
          end
          default: ;
        endcase
      end
      m_stamp = m_stamp + 32'd1;
    end
  endtask

  task automatic check_outputs();
    logic exp_valid;
    exp_valid = (m_state == 3) && (q.size() != 0);
    chk("state", state, m_state);
    chk("count", count, q.size());
    chk("overflow", overflow, m_ovf);
    chk("rd_valid", rd_valid, exp_valid);
    if (exp_valid) begin
      chk("rd_pc", rd_pc, q[0].pc);
      chk("rd_inst", rd_inst, q[0].inst);
      chk("rd_stamp", rd_stamp, q[0].stamp);
`ifdef TRACE_WB_EN
      chk("rd_wb", rd_wb, q[0].wb);
`endif
    end else begin
      chk("rd_pc_idle", rd_pc, 0);
      chk("rd_stamp_idle", rd_stamp, 0);
    end
  endtask

  task automatic tick();
    @(posedge clk_in);
    model_step();
    #1;
    check_outputs();
  endtask

  task automatic commit(input logic [31:0] pc);
    commit_valid = 1'b1;
    commit_pc    = pc;
    commit_inst  = $urandom;
    tick();
    commit_valid = 1'b0;
  endtask

  task automatic start(input logic md, input logic te, input logic [31:0] tp);
    mode    = md;
    trig_en = te;
    trig_pc = tp;
    arm     = 1'b1;
    tick();
    arm     = 1'b0;
  endtask

  task automatic drain_expect(input string tag, input logic [31:0] pcs[$]);
    logic [31:0] prev;
    rd_ready = 1'b1;
    prev = '0;
    foreach (pcs[i]) begin
      chk(tag, rd_pc, pcs[i]);
      if (i > 0) chk("stamp_increasing", rd_stamp > prev, 1'b1);
      prev = rd_stamp;
      tick();
    end
    rd_ready = 1'b0;
    chk("idle_after_drain", state, 2'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // 1: reset
    reset = 1'b0;
    tick();
    tick();
    chk("rst_state", state, 2'd0);
    chk("rst_count", count, 3'd0);
    chk("rst_rd_valid", rd_valid, 1'b0);
    chk("rst_overflow", overflow, 1'b0);
    reset = 1'b1;
    tick();

    // 2: stop-when-full
    start(1'b0, 1'b0, 32'h0);
    tick();
    commit(32'h0);
    commit(32'h4);
    commit(32'h8);
    commit(32'hC);
    chk("t2_done", state, 2'd3);
    commit(32'h10);
    chk("t2_count", count, 3'd4);
    drain_expect("t2_drain", '{32'h0, 32'h4, 32'h8, 32'hC});

    // 3: wrap mode keeps the last DEPTH
    start(1'b1, 1'b0, 32'h0);
    tick();
    for (int i = 0; i < 6; i++) commit(32'(i * 4));
    stop = 1'b1;
    tick();
    stop = 1'b0;
    chk("t3_count", count, 3'd4);
    chk("t3_overflow", overflow, 1'b1);
    drain_expect("t3_drain", '{32'h08, 32'h0C, 32'h10, 32'h14});

    // 4: trigger pc, show-ahead held while not ready
    start(1'b0, 1'b1, 32'h40);
    commit(32'h3C);
    commit(32'h40);
    commit(32'h44);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    chk("t4_count", count, 3'd2);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("t4_hold", rd_pc, 32'h40);
    end
    drain_expect("t4_drain", '{32'h40, 32'h44});

    // 5: commit with stop is kept; arm in DONE discards unread entries
    start(1'b0, 1'b0, 32'h0);
    tick();
    commit(32'h18);
    commit(32'h1C);
    stop = 1'b1;
    commit(32'h20);
    stop = 1'b0;
    chk("t5_count", count, 3'd3);
    rd_ready = 1'b1;
    tick();
    rd_ready = 1'b0;
    chk("t5_head", rd_pc, 32'h1C);
    chk("t5_unread", count, 3'd2);
    start(1'b0, 1'b0, 32'h0);
    chk("t5_rearm_count", count, 3'd0);
    chk("t5_rearm_state", state, 2'd1);

    // 6: reset mid-capture
    tick();
    commit(32'h100);
    commit(32'h104);
    commit(32'h108);
    chk("t6_pre_count", count, 3'd3);
    reset = 1'b0;
    tick();
    reset = 1'b1;
    chk("t6_state", state, 2'd0);
    chk("t6_count", count, 3'd0);

`ifdef TRACE_WB_EN
    start(1'b0, 1'b0, 32'h0);
    tick();
    wb_en   = 1'b1;
    wb_rd   = 5'd5;
    wb_data = 32'hDEADBEEF;
    commit(32'h200);
    wb_en   = 1'b0;
    stop = 1'b1;
    tick();
    stop = 1'b0;
    chk("wb_field", rd_wb, {1'b1, 5'd5, 32'hDEADBEEF});
    rd_ready = 1'b1;
    tick();
    rd_ready = 1'b0;
`endif

    // random traffic
    for (int c = 0; c < 800; c++) begin
      reset = ($urandom_range(0, 199) != 0);
      arm   = ($urandom_range(0, 29) == 0);
      if (arm) begin
        mode    = $urandom_range(0, 1);
        trig_en = $urandom_range(0, 1);
        trig_pc = {26'd0, 4'($urandom_range(0, 15)), 2'b00};
      end
      commit_valid = $urandom_range(0, 1);
      commit_pc    = {26'd0, 4'($urandom_range(0, 15)), 2'b00};
      commit_inst  = $urandom;
      wb_en        = $urandom_range(0, 1);
      wb_rd        = 5'($urandom);
      wb_data      = $urandom;
      stop         = (m_state >= 2) && ($urandom_range(0, 14) == 0);
      rd_ready     = $urandom_range(0, 1);
      tick();
    end
    arm = 1'b0;
    stop = 1'b0;
    commit_valid = 1'b0;
    reset = 1'b1;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
